// File: rtl/simon_core.sv
// simon_core: iterative SIMON block cipher, one round per clock.
// The key is expanded once into an internal round-key file and reused for
// every block until the next key_load or reset.
// Optional feature: define SIMON_DECRYPT_EN to honour `mode` and build the
// decrypt round path and down-counting key index. Without it the core is
// encrypt-only and `mode` is ignored.
module simon_core #(
  parameter int WORD_SIZE = 64,
  parameter int KEY_WORDS = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [KEY_WORDS*WORD_SIZE-1:0] key_in,
  input  logic                           key_load,
  input  logic [2*WORD_SIZE-1:0]         data_in,
  input  logic                           mode,
  input  logic                           start,
  output logic                           key_ready,
  output logic                           ready,
  output logic                           done,
  output logic [2*WORD_SIZE-1:0]         data_out
);
  localparam int N = WORD_SIZE;
  localparam int M = KEY_WORDS;

  // Round count T for each standard block/key pair.
  localparam int ROUNDS =
    (N == 16) ? 32 :
    (N == 24) ? 36 :
    (N == 32) ? ((M == 3) ? 42 : 44) :
    (N == 48) ? ((M == 2) ? 52 : 54) :
                ((M == 2) ? 68 : (M == 3) ? 69 : 72);

  // Round-constant sequences z0..z4, bit 0 is consumed first.
  localparam logic [61:0] Z0 = 62'b01100111000011010100100010111110110011100001101010010001011111;
  localparam logic [61:0] Z1 = 62'b01011010000110010011111011100010101101000011001001111101110001;
  localparam logic [61:0] Z2 = 62'b11001101101001111110001000010100011001001011000000111011110101;
  localparam logic [61:0] Z3 = 62'b11110000101100111001010001001000000111101001100011010111011011;
  localparam logic [61:0] Z4 = 62'b11110111001001010011000011101000000100011011010110011110001011;
  localparam logic [61:0] Z_SEQ =
    (N == 16) ? Z0 :
    (N == 24) ? ((M == 3) ? Z0 : Z1) :
    (N == 32) ? ((M == 3) ? Z2 : Z3) :
    (N == 48) ? ((M == 2) ? Z2 : Z3) :
                ((M == 2) ? Z2 : (M == 3) ? Z3 : Z4);

  localparam int            CW   = $clog2(ROUNDS);
  localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_KEYEXP = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  function automatic logic [N-1:0] rotl(input logic [N-1:0] v, input int s);
    return (v << s) | (v >> (N - s));
  endfunction

  function automatic logic [N-1:0] ror(input logic [N-1:0] v, input int s);
    return rotl(v, N - s);
  endfunction

  function automatic logic [N-1:0] round_f(input logic [N-1:0] v);
    return (rotl(v, 1) & rotl(v, 8)) ^ rotl(v, 2);
  endfunction

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [61:0]   z_reg;
  logic [N-1:0]  key_file [ROUNDS];
  logic [N-1:0]  x_q, y_q, rk, nx, ny;
  logic [N-1:0]  key_word, gen_word, tmp, k_prev, k_back3, k_backm;
  logic [CW-1:0] key_idx;

`ifdef SIMON_DECRYPT_EN
  logic          mode_q;
  logic [CW-1:0] rnd;
  assign key_idx = rnd;
`else
  logic mode_unused;
  assign mode_unused = mode;
  assign key_idx     = cnt;
`endif

  assign ready = (state == S_IDLE) && key_ready && !key_load;
  assign done  = (state == S_DONE);
  assign rk    = key_file[key_idx];

  // Next key-file word: raw key words for the first M cycles, generated words after.
  // NOTE: every variable gets a default at the top of the block so no path leaves one unassigned (no latch).
  always_comb begin
    key_word = '0;
    for (int i = 0; i < M; i++)
      if (cnt == CW'(i)) key_word = key_in[i*N +: N];
    k_prev  = '0;
    k_back3 = '0;
    k_backm = '0;
    if (cnt >= CW'(M)) begin
      k_prev  = key_file[cnt - CW'(1)];
      k_backm = key_file[cnt - CW'(M)];
      if (M == 4) k_back3 = key_file[cnt - CW'(3)];
    end
    tmp      = ror(k_prev, 3) ^ k_back3;
    tmp      = tmp ^ ror(tmp, 1);
    gen_word = ~k_backm ^ tmp ^ N'(3) ^ N'(z_reg[0]);
  end

  // One SIMON round on the working block, forward or inverse.
  always_comb begin
    nx = y_q ^ round_f(x_q) ^ rk;
    ny = x_q;
`ifdef SIMON_DECRYPT_EN
    if (mode_q) begin
      nx = y_q;
      ny = x_q ^ round_f(y_q) ^ rk;
    end
`endif
  end

  // Round-key file write port, active only during expansion.
  // NOTE: the key file has no reset; it is only trusted while key_ready is high, so clearing it would buy nothing.
  always_ff @(posedge clk) begin
    if (!reset && state == S_KEYEXP)
      key_file[cnt] <= (cnt < CW'(M)) ? key_word : gen_word;
  end

  // Control FSM, working block, round index and output register.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      key_ready <= 1'b0;
      data_out  <= '0;
      x_q       <= '0;
      y_q       <= '0;
      z_reg     <= Z_SEQ;
`ifdef SIMON_DECRYPT_EN
      mode_q    <= 1'b0;
      rnd       <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (key_load) begin
            state     <= S_KEYEXP;
            cnt       <= '0;
            key_ready <= 1'b0;
            z_reg     <= Z_SEQ;
          end else if (start && key_ready) begin
            state <= S_RUN;
            cnt   <= '0;
            x_q   <= data_in[2*N-1:N];
            y_q   <= data_in[N-1:0];
`ifdef SIMON_DECRYPT_EN
            mode_q <= mode;
            rnd    <= mode ? LAST : '0;
`endif
          end
        end
        S_KEYEXP: begin
          if (cnt >= CW'(M)) z_reg <= {z_reg[0], z_reg[61:1]};
          if (cnt == LAST) begin
            state     <= S_IDLE;
            key_ready <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_RUN: begin
          x_q <= nx;
          y_q <= ny;
`ifdef SIMON_DECRYPT_EN
          rnd <= mode_q ? rnd - CW'(1) : rnd + CW'(1);
`endif
          if (cnt == LAST) begin
            state    <= S_DONE;
            data_out <= {nx, ny};
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_core.sv
// Bench for simon_core: a Simon32/64 instance (A) and a Simon64/128 instance (B)
// checked every cycle against a transaction-level model, plus literal vectors.
`timescale 1ns/1ps
module tb_simon_core;
`ifdef SIMON_DECRYPT_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic [63:0]  a_key;
  logic         a_kl, a_md, a_st, a_kr, a_rdy, a_done;
  logic [31:0]  a_din, a_dout;

  logic [127:0] b_key;
  logic         b_kl, b_md, b_st, b_kr, b_rdy, b_done;
  logic [63:0]  b_din, b_dout;

  simon_core #(.WORD_SIZE(16), .KEY_WORDS(4)) u_a (
    .clk(clk), .reset(reset), .key_in(a_key), .key_load(a_kl), .data_in(a_din),
    .mode(a_md), .start(a_st), .key_ready(a_kr), .ready(a_rdy), .done(a_done),
    .data_out(a_dout));

  simon_core #(.WORD_SIZE(32), .KEY_WORDS(4)) u_b (
    .clk(clk), .reset(reset), .key_in(b_key), .key_load(b_kl), .data_in(b_din),
    .mode(b_md), .start(b_st), .key_ready(b_kr), .ready(b_rdy), .done(b_done),
    .data_out(b_dout));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference cipher ----------------
  function automatic int t_rounds(input int n, input int m);
    case (n * 10 + m)
      164: return 32;  243: return 36;  244: return 36;
      323: return 42;  324: return 44;  482: return 52;
      483: return 54;  642: return 68;  643: return 69;
      default: return 72;
    endcase
  endfunction

  function automatic logic [61:0] z_of(input int n, input int m);
    logic [61:0] z [5];
    z[0] = 62'b01100111000011010100100010111110110011100001101010010001011111;
    z[1] = 62'b01011010000110010011111011100010101101000011001001111101110001;
    z[2] = 62'b11001101101001111110001000010100011001001011000000111011110101;
    z[3] = 62'b11110000101100111001010001001000000111101001100011010111011011;
    z[4] = 62'b11110111001001010011000011101000000100011011010110011110001011;
    case (n * 10 + m)
      164, 243: return z[0];
      244:      return z[1];
      323, 482, 642: return z[2];
      324, 483, 643: return z[3];
      default:  return z[4];
    endcase
  endfunction

  function automatic logic [63:0] msk(input int n);
    return (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
  endfunction

  function automatic logic [63:0] rotl_w(input logic [63:0] v, input int s, input int n);
    logic [63:0] w;
    w = v & msk(n);
    return ((w << s) | (w >> (n - s))) & msk(n);
  endfunction

  function automatic logic [63:0] f_w(input logic [63:0] v, input int n);
    return (rotl_w(v, 1, n) & rotl_w(v, 8, n)) ^ rotl_w(v, 2, n);
  endfunction

  function automatic logic [127:0] simon_ref(input int n, input int m, input logic [255:0] key,
                                             input logic [127:0] blk, input bit dec);
    logic [63:0] k [72];
    logic [63:0] x, y, tmp, mk;
    logic [61:0] z;
    int t;
    t  = t_rounds(n, m);
    z  = z_of(n, m);
    mk = msk(n);
    for (int i = 0; i < m; i++) k[i] = 64'(key >> (i * n)) & mk;
    for (int i = m; i < t; i++) begin
      tmp = rotl_w(k[i-1], n - 3, n);
      if (m == 4) tmp = tmp ^ k[i-3];
      tmp  = tmp ^ rotl_w(tmp, n - 1, n);
      k[i] = (~k[i-m] & mk) ^ tmp ^ 64'(z[(i - m) % 62]) ^ 64'd3;
    end
    x = 64'(blk >> n) & mk;
    y = 64'(blk) & mk;
    if (!dec) begin
      for (int r = 0; r < t; r++) begin
        tmp = x;
        x   = (y ^ f_w(x, n) ^ k[r]) & mk;
        y   = tmp;
      end
    end else begin
      for (int r = t - 1; r >= 0; r--) begin
        tmp = y;
        y   = (x ^ f_w(y, n) ^ k[r]) & mk;
        x   = tmp;
      end
    end
    return (128'(x) << n) | 128'(y);
  endfunction

  // ---------------- transaction-level timing model ----------------
  int           dn [2] = '{16, 32};
  int           dm [2] = '{4, 4};
  bit           armed = 1'b0;
  bit           kr_valid [2];
  int           kr_at [2];
  int           busy_end [2];
  int           done_at [2];
  logic [127:0] pending [2];
  logic [127:0] out_exp [2];

  task automatic model_step(input int d, input logic rst, input logic kl, input logic st,
                            input logic md, input logic [255:0] key, input logic [127:0] din);
    int now, t;
    now = cyc;
    t   = t_rounds(dn[d], dm[d]);
    if (rst) begin
      armed       = 1'b1;
      kr_valid[d] = 1'b0;
      busy_end[d] = -1;
      done_at[d]  = -1;
      out_exp[d]  = '0;
    end else begin
      if (now > busy_end[d]) begin
        if (kl) begin
          kr_valid[d] = 1'b1;
          kr_at[d]    = now + t + 1;
          busy_end[d] = now + t;
        end else if (st && kr_valid[d] && now >= kr_at[d]) begin
          busy_end[d] = now + t + 1;
          done_at[d]  = now + t + 1;
          pending[d]  = simon_ref(dn[d], dm[d], key, din, md & DEC_EN);
        end
      end
      if (now + 1 == done_at[d]) out_exp[d] = pending[d];
    end
  endtask

  // Model advances on each rising edge using the inputs the DUT samples there.
  always @(posedge clk) begin
    model_step(0, reset, a_kl, a_st, a_md, 256'(a_key), 128'(a_din));
    model_step(1, reset, b_kl, b_st, b_md, 256'(b_key), 128'(b_din));
    cyc++;
  end

  task automatic cmp_dut(input int d, input string p, input logic dn_o, input logic kr_o,
                         input logic rdy_o, input logic [127:0] dout_o, input logic kl_i);
    bit ekr, eidle;
    ekr   = kr_valid[d] && (cyc >= kr_at[d]);
    eidle = cyc > busy_end[d];
    check({p, ".done"},      128'(dn_o),  128'(cyc == done_at[d]));
    check({p, ".key_ready"}, 128'(kr_o),  128'(ekr));
    check({p, ".ready"},     128'(rdy_o), 128'(eidle && ekr && !kl_i));
    check({p, ".data_out"},  dout_o,      out_exp[d]);
  endtask

  // Single compare process: every output of both instances, every cycle after reset.
  always @(negedge clk) begin
    if (armed) begin
      cmp_dut(0, "A", a_done, a_kr, a_rdy, 128'(a_dout), a_kl);
      cmp_dut(1, "B", b_done, b_kr, b_rdy, 128'(b_dout), b_kl);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input int d, input logic kl, input logic st, input logic md,
                       input logic [127:0] din);
    if (d == 0) begin
      a_kl = kl; a_st = st; a_md = md; a_din = din[31:0];
    end else begin
      b_kl = kl; b_st = st; b_md = md; b_din = din[63:0];
    end
  endtask

  function automatic logic get_done(input int d);
    return (d == 0) ? a_done : b_done;
  endfunction
  function automatic logic get_kr(input int d);
    return (d == 0) ? a_kr : b_kr;
  endfunction
  function automatic logic get_ready(input int d);
    return (d == 0) ? a_rdy : b_rdy;
  endfunction
  function automatic logic [127:0] get_dout(input int d);
    return (d == 0) ? 128'(a_dout) : 128'(b_dout);
  endfunction

  task automatic wait_ready(input int d);
    int w = 0;
    while (!get_ready(d) && w < 100) begin
      tick();
      w++;
    end
    if (w >= 100) check("ready timeout", 128'(get_ready(d)), 128'(1));
  endtask

  // Pulse key_load (optionally with start in the same cycle, or a start mid-expansion)
  // and count the cycles key_ready stays low.
  task automatic load_key(input int d, input bit with_start, input bit poke,
                          output int zeros, output bit saw_done);
    drive(d, 1'b1, with_start, 1'b0, 128'h0123_4567);
    tick();
    drive(d, 1'b0, 1'b0, 1'b0, '0);
    zeros    = 0;
    saw_done = 1'b0;
    while (!get_kr(d) && zeros < 200) begin
      zeros++;
      drive(d, 1'b0, poke && zeros == 5, 1'b0, 128'h0123_4567);
      tick();
      if (get_done(d)) saw_done = 1'b1;
    end
    drive(d, 1'b0, 1'b0, 1'b0, '0);
    if (zeros >= 200) check("key_ready timeout", 128'(get_kr(d)), 128'(1));
  endtask

  task automatic run_block(input int d, input logic [127:0] din, input logic md,
                           output int lat, output logic [127:0] res, output int dcyc);
    wait_ready(d);
    drive(d, 1'b0, 1'b1, md, din);
    tick();
    drive(d, 1'b0, 1'b0, md, din);
    lat = 1;
    while (!get_done(d) && lat < 300) begin
      tick();
      lat++;
    end
    if (lat >= 300) check("done timeout", 128'(get_done(d)), 128'(1));
    res  = get_dout(d);
    dcyc = cyc;
  endtask

  // ---------------- directed test sequence ----------------
  initial begin
    int           zeros, lat, dc1, dc2;
    bit           saw;
    logic [127:0] res;

    reset = 1'b1;
    a_key = 64'h1918_1110_0908_0100;
    b_key = 128'h1b1a1918_13121110_0b0a0908_03020100;
    drive(0, 1'b0, 1'b0, 1'b0, '0);
    drive(1, 1'b0, 1'b0, 1'b0, '0);
    repeat (3) tick();
    reset = 1'b0;

    // Reference model pinned by published vectors.
    check("ref 32/64 enc", simon_ref(16, 4, 256'(a_key), 128'h6565_6877, 1'b0), 128'hc69b_e9bb);
    check("ref 64/128 enc", simon_ref(32, 4, 256'(b_key), 128'h656b696c_20646e75, 1'b0),
          128'h44c8fc20_b9dfa07a);
    check("ref 64/128 dec", simon_ref(32, 4, 256'(b_key), 128'h44c8fc20_b9dfa07a, 1'b1),
          128'h656b696c_20646e75);

    // Reset values.
    check("A.reset key_ready", 128'(a_kr), 128'(0));
    check("A.reset ready", 128'(a_rdy), 128'(0));
    check("B.reset done", 128'(b_done), 128'(0));
    check("B.reset data_out", 128'(b_dout), 128'(0));

    // Simon32/64: expansion, encrypt, then mode=1.
    load_key(0, 1'b0, 1'b0, zeros, saw);
    check("A.keyexp low cycles", 128'(zeros), 128'(32));
    run_block(0, 128'h6565_6877, 1'b0, lat, res, dc1);
    check("A.enc latency", 128'(lat), 128'(33));
    check("A.enc ct", res, 128'hc69b_e9bb);
    run_block(0, 128'h6565_6877, 1'b1, lat, res, dc1);
    check("A.mode1 latency", 128'(lat), 128'(33));
`ifndef SIMON_DECRYPT_EN
    check("A.mode ignored ct", res, 128'hc69b_e9bb);
`endif

    // Simon64/128: expansion with a start issued mid-expansion.
    load_key(1, 1'b0, 1'b1, zeros, saw);
    check("B.keyexp low cycles", 128'(zeros), 128'(44));
    check("B.no done during keyexp", 128'(saw), 128'(0));

    // Back-to-back encrypts under one key.
    run_block(1, 128'h656b696c_20646e75, 1'b0, lat, res, dc1);
    check("B.enc latency", 128'(lat), 128'(45));
    check("B.enc ct", res, 128'h44c8fc20_b9dfa07a);
    run_block(1, 128'h01234567_89abcdef, 1'b0, lat, res, dc2);
    check("B.back-to-back spacing", 128'(dc2 - dc1), 128'(46));

    // Decrypt request.
    run_block(1, 128'h44c8fc20_b9dfa07a, 1'b1, lat, res, dc1);
    check("B.mode1 latency", 128'(lat), 128'(45));
`ifdef SIMON_DECRYPT_EN
    check("B.dec pt", res, 128'h656b696c_20646e75);
`endif

    // key_load and start together in IDLE: only expansion happens.
    wait_ready(1);
    load_key(1, 1'b1, 1'b0, zeros, saw);
    check("B.same-cycle keyexp cycles", 128'(zeros), 128'(44));
    check("B.same-cycle no done", 128'(saw), 128'(0));

    // Reset at round 10 of a block.
    wait_ready(1);
    drive(1, 1'b0, 1'b1, 1'b0, 128'h656b696c_20646e75);
    tick();
    drive(1, 1'b0, 1'b0, 1'b0, 128'h656b696c_20646e75);
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("B.midrun reset data_out", 128'(b_dout), 128'(0));
    check("B.midrun reset key_ready", 128'(b_kr), 128'(0));
    check("B.midrun reset ready", 128'(b_rdy), 128'(0));
    saw = 1'b0;
    repeat (60) begin
      tick();
      if (b_done) saw = 1'b1;
    end
    check("B.midrun no done", 128'(saw), 128'(0));

    // Recovery after reset.
    load_key(1, 1'b0, 1'b0, zeros, saw);
    run_block(1, 128'h656b696c_20646e75, 1'b0, lat, res, dc1);
    check("B.post-reset ct", res, 128'h44c8fc20_b9dfa07a);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/simon_core.md
# simon_core

Parametrised SIMON block-cipher engine; successor to the fixed-width `simon` top. It supports every standard SIMON block/key combination and expands the key once into an internal round-key file. Blocks are then processed iteratively, one round per clock, in encrypt or decrypt mode. It sits between the host load interface and the cipher datapath of the SIMON subsystem.

## Interface
- `WORD_SIZE`, default 64: word width n, in bits; legal values 16, 24, 32, 48, 64. Block = 2n.
- `KEY_WORDS`, default 2: m; legal values 2, 3, 4, restricted to standard SIMON pairs. Key = m·n.
- `ROUNDS`, derived, not overridable: T from the SIMON table, e.g. 32/64→32, 64/128→44, 128/128→68, 128/256→72.
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `key_in`  in  KEY_WORDS·WORD_SIZE  key words {k[m-1],…,k[0]}.
- `key_load`  in  1  1-cycle request to expand `key_in`.
- `data_in`  in  2·WORD_SIZE  block {x,y}, with x as the upper word.
- `mode`  in  1  0 = encrypt, 1 = decrypt; sampled together with `start`.
- `start`  in  1  begin one block.
- `key_ready`  out  1  the round-key file is valid.
- `ready`  out  1  `start` will be accepted this cycle.
- `done`  out  1  1-cycle pulse; `data_out` is valid.
- `data_out`  out  2·WORD_SIZE  result {x,y}; held stable until the next accepted `start`.

## Operation
- FSM states: IDLE, KEYEXP, RUN, DONE.
- **IDLE:**
  - `key_load`=1 → KEYEXP. The cycle counter is cleared and `key_ready` is cleared.
  - Otherwise, `start`=1 with `key_ready`=1 → RUN. `data_in` and `mode` are latched, and the round counter is set to 0 (encrypt) or T−1 (decrypt).
- **KEYEXP:**
  - Cycles 0..m−1 write k[i] from `key_in` into the key file.
  - Cycles m..T−1 write one generated word per cycle:
    - tmp = ROR3(k[i−1]);
    - if m=4, tmp ^= k[i−3];
    - tmp ^= ROR1(tmp);
    - k[i] = ~k[i−m] ^ tmp ^ z_j[(i−m) mod 62] ^ 3.
  - The constant sequence z_j is chosen per the SIMON table (z0..z4).
  - After T cycles: → IDLE, and `key_ready`=1.
- **RUN:** one round per cycle, where f(v) = (ROL1 v & ROL8 v) ^ ROL2 v, mod 2^n.
  - Encrypt: (x,y) ← (y ^ f(x) ^ k[r], x); r increments.
  - Decrypt: (x,y) ← (y, x ^ f(y) ^ k[r]); r decrements.
  - After T rounds: → DONE.
- **DONE:** `done`=1 and `data_out` is updated → IDLE.
- **Ignored requests:**
  - `start` is ignored outside IDLE, and also when `key_ready`=0.
  - `key_load` is ignored outside IDLE.
  - If `key_load` and `start` arrive in the same IDLE cycle, `key_load` wins and `start` is dropped.
- **Key file:** T × n registers, read asynchronously. It is not cleared by reset; `key_ready` gates its use.
- **Key reuse:** the key stays valid across any number of blocks until the next `key_load` or `reset`.

## Timing
- **Reset values:** state IDLE; `key_ready`=0, `ready`=0, `done`=0, `data_out`=0.
- **ready** = (state==IDLE) & `key_ready` & ~`key_load`. It is combinational from state.
- **Key expansion:** `key_load` in cycle t → `key_ready`=1 in cycle t+T+1.
- **Block latency:** `start` accepted in cycle t → rounds in cycles t+1..t+T → `done`=1 in cycle t+T+1.
- **Data output timing:** `data_out` changes only at the edge entering DONE.
- **Back-to-back:** `ready` is high in cycle t+T+2. Throughput is one block per T+2 cycles.
- **Reset mid-operation:** `reset` in KEYEXP or RUN returns to IDLE on the next edge. Outputs take their reset values and no `done` is emitted.

## Configuration
- `SIMON_DECRYPT_EN` defined: `mode` is honoured and the decrypt round path plus the down-counting key index are built.
- `SIMON_DECRYPT_EN` undefined: encrypt only, and `mode` is ignored (treated as 0). The decrypt mux and down-counter are not synthesised; latency is unchanged.

## Test plan
- **Simon32/64 encrypt** (n=16, m=4):
  - key 1918_1110_0908_0100, pt 6565_6877.
  - `done` 33 cycles after `start`; ct = c69b_e9bb.
- **Simon64/128 decrypt** (`SIMON_DECRYPT_EN`):
  - key 1b1a1918_13121110_0b0a0908_03020100, ct 44c8fc20_b9dfa07a.
  - pt = 656b696c_20646e75, 45 cycles after `start`.
- **Key expansion timing** (64/128): `key_load` pulse → `key_ready`=0 for 44 cycles, then 1. `start` issued during KEYEXP produces no `done`.
- **Back-to-back encrypt + same-cycle requests:** two blocks under one key give two correct ciphertexts with `done` 46 cycles apart. `key_load` and `start` asserted together in IDLE → only KEYEXP occurs.
- **Reset mid-RUN:** `reset` at round 10 → next cycle `data_out`=0, `key_ready`=0, `ready`=0, and no `done` pulse.
- **Build without the macro:** encrypt with `mode`=1 → output equals the encrypt ciphertext (c69b_e9bb for the 32/64 vector).
